icache_assoc: RTL and testbench

- Parametrised set-associative instruction cache. Successor to the direct-mapped 8-line instruction cache.
- Sits between the CPU fetch stage (PC address in, 32-bit instruction out) and the block-wide instruction memory.
- New relative to the previous generation:
  - configurable sets, ways and block size;
  - round-robin replacement;
  - synchronous flush;
  - saturating hit/miss counters;
  - latched miss address.

---
 rtl/icache_pkg.sv | 38 +++
 rtl/icache_way.sv | 51 +++++
 rtl/icache_assoc.sv | 170 +++++++++++++++++
 tb/tb_icache_assoc.sv | 252 +++++++++++++++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared definitions for the set-associative instruction cache: controller
// state encoding and the address-field width helpers.
package icache_pkg;

  localparam logic [1:0] IDLE        = 2'b00;
  localparam logic [1:0] MEM_READ    = 2'b01;
  localparam logic [1:0] CACHE_WRITE = 2'b11;
  localparam logic [1:0] FLUSH       = 2'b10;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++)
      if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

  function automatic int max1(input int v);
    return (v < 1) ? 1 : v;
  endfunction

  function automatic int wo_bits(input int words);
    return clog2(words);
  endfunction

  function automatic int ix_bits(input int sets);
    return clog2(sets);
  endfunction

  function automatic int tag_bits(input int addr_w, input int words, input int sets);
    return addr_w - 2 - clog2(words) - clog2(sets);
  endfunction

  localparam int WO_DEF    = wo_bits(4);
  localparam int IX_DEF    = ix_bits(4);
  localparam int TAG_W_DEF = tag_bits(10, 4, 4);

endpackage

// File: rtl/icache_way.sv
// One way of the cache: per-set valid bit, tag and block storage, with the
// lookup-side tag compare and word select.
module icache_way
  import icache_pkg::*;
#(
  parameter int WORDS = 4,
  parameter int SETS  = 4,
  parameter int TAG_W = 4,
  localparam int WO = wo_bits(WORDS),
  localparam int IX = ix_bits(SETS)
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  flush_all,
  input  logic [IX-1:0]         look_index,
  input  logic [TAG_W-1:0]      look_tag,
  input  logic [WO-1:0]         look_word,
  output logic                  match,
  output logic [31:0]           word,
  input  logic [IX-1:0]         fill_index,
  output logic                  fill_valid,
  input  logic                  write_en,
  input  logic [TAG_W-1:0]      write_tag,
  input  logic [32*WORDS-1:0]   write_block
);

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tag_q  [SETS];
  logic [31:0]      data_q [SETS][WORDS];

  always_ff @(posedge clock) begin
    if (!reset || flush_all)
      valid <= '0;
    else if (write_en)
      valid[fill_index] <= 1'b1;
  end

  // Tag and data storage carry no reset; the valid bit guards them.
  always_ff @(posedge clock) begin
    if (write_en) begin
      tag_q[fill_index] <= write_tag;
      for (int k = 0; k < WORDS; k++)
        data_q[fill_index][k] <= write_block[32*k +: 32];
    end
  end

  assign match      = valid[look_index] && (tag_q[look_index] == look_tag);
  assign word       = data_q[look_index][look_word];
  assign fill_valid = valid[fill_index];

endmodule

// File: rtl/icache_assoc.sv
// Set-associative instruction cache: miss/fill/flush controller, round-robin
// replacement and saturating hit/miss counters around WAYS icache_way slices.
module icache_assoc
  import icache_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int WORDS  = 4,
  parameter int SETS   = 4,
  parameter int WAYS   = 2,
  parameter int CNT_W  = 16,
  localparam int WO    = wo_bits(WORDS),
  localparam int IX    = ix_bits(SETS),
  localparam int TAG_W = tag_bits(ADDR_W, WORDS, SETS),
  localparam int BA_W  = TAG_W + IX,
  localparam int VW    = max1(clog2(WAYS))
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                read,
  input  logic [ADDR_W-1:0]   address,
  input  logic                flush,
  output logic [31:0]         readdata,
  output logic                cache_busywait,
  output logic                mem_read,
  output logic [BA_W-1:0]     mem_address,
  input  logic [32*WORDS-1:0] mem_readdata,
  input  logic                mem_busywait,
  output logic [CNT_W-1:0]    hit_count,
  output logic [CNT_W-1:0]    miss_count
);

  logic [1:0]          state, next_state;
  logic                flush_pending;
  logic [BA_W-1:0]     blk_q;
  logic [32*WORDS-1:0] fill_data_q;

  logic [WO-1:0]       look_word;
  logic [IX-1:0]       look_index;
  logic [TAG_W-1:0]    look_tag;
  logic [1:0]          unused_byte;
  logic [IX-1:0]       fill_index;
  logic [TAG_W-1:0]    fill_tag;

  logic [WAYS-1:0]     way_match;
  logic [WAYS-1:0]     way_valid;
  logic [WAYS-1:0]     way_write;
  logic [31:0]         way_word [WAYS];

  logic                hit, start_miss, write_en, flush_all, all_valid;
  logic [VW-1:0]       victim, ptr_cur;

  assign look_word   = address[2 +: WO];
  assign look_index  = address[2+WO +: IX];
  assign look_tag    = address[2+WO+IX +: TAG_W];
  assign unused_byte = address[1:0];
  assign fill_index  = blk_q[IX-1:0];
  assign fill_tag    = blk_q[IX +: TAG_W];

  for (genvar w = 0; w < WAYS; w++) begin : g_way
    icache_way #(
      .WORDS (WORDS),
      .SETS  (SETS),
      .TAG_W (TAG_W)
    ) u_way (
      .clock       (clock),
      .reset       (reset),
      .flush_all   (flush_all),
      .look_index  (look_index),
      .look_tag    (look_tag),
      .look_word   (look_word),
      .match       (way_match[w]),
      .word        (way_word[w]),
      .fill_index  (fill_index),
      .fill_valid  (way_valid[w]),
      .write_en    (way_write[w]),
      .write_tag   (fill_tag),
      .write_block (fill_data_q)
    );
    assign way_write[w] = write_en && (victim == VW'(w));
  end

  assign hit        = read && (state == IDLE) && $onehot(way_match);
  assign start_miss = (state == IDLE) && !flush && read && !hit;

  always_comb begin
    readdata = '0;
    if (hit)
      for (int w = 0; w < WAYS; w++)
        if (way_match[w]) readdata = readdata | way_word[w];
  end

  // Fill the lowest invalid way first; only a full set consults the pointer.
  assign all_valid = &way_valid;

  always_comb begin
    victim = ptr_cur;
    for (int w = WAYS - 1; w >= 0; w--)
      if (!way_valid[w]) victim = VW'(w);
  end

  if (WAYS > 1) begin : g_ptr
    logic [VW-1:0] ptr_q [SETS];

    always_ff @(posedge clock) begin
      if (!reset || flush_all) begin
        for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
      end else if (write_en && all_valid) begin
        ptr_q[fill_index] <= (ptr_q[fill_index] == VW'(WAYS - 1)) ? '0
                             : ptr_q[fill_index] + VW'(1);
      end
    end

    assign ptr_cur = ptr_q[fill_index];
  end else begin : g_no_ptr
    assign ptr_cur = '0;
  end

  always_ff @(posedge clock) begin
    if (!reset) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (flush)            next_state = FLUSH;
        else if (read && !hit) next_state = MEM_READ;
      end
      MEM_READ:    if (!mem_busywait) next_state = CACHE_WRITE;
      CACHE_WRITE: next_state = (flush_pending || flush) ? FLUSH : IDLE;
      FLUSH:       next_state = IDLE;
      default:     next_state = IDLE;
    endcase
  end

  always_comb begin
    mem_read       = (state == MEM_READ);
    mem_address    = mem_read ? blk_q : '0;
    write_en       = (state == CACHE_WRITE);
    flush_all      = (state == FLUSH);
    cache_busywait = (state != IDLE) || (read && !hit) || flush_pending;
  end

  // A flush seen mid-fill is deferred until the block has been written.
  always_ff @(posedge clock) begin
    if (!reset)
      flush_pending <= 1'b0;
    else if (state == FLUSH)
      flush_pending <= 1'b0;
    else if (flush && (state == MEM_READ || state == CACHE_WRITE))
      flush_pending <= 1'b1;
  end

  always_ff @(posedge clock) begin
    if (start_miss) blk_q <= address[ADDR_W-1 -: BA_W];
    if (state == MEM_READ && !mem_busywait) fill_data_q <= mem_readdata;
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else begin
      if (hit && hit_count != '1)         hit_count  <= hit_count + CNT_W'(1);
      if (start_miss && miss_count != '1) miss_count <= miss_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_icache_assoc.sv
// Bench for icache_assoc: table of fetches/flushes plus hand-built sequences
// for mid-fill flush, mid-fill reset and counter saturation.
module tb_icache_assoc;

  localparam int LAT = 5;

  logic         clock;
  logic         reset;
  logic         read;
  logic [9:0]   address;
  logic         flush;
  logic [31:0]  readdata;
  logic         cache_busywait;
  logic         mem_read;
  logic [5:0]   mem_address;
  logic [127:0] mem_readdata;
  logic         mem_busywait;
  logic [15:0]  hit_count;
  logic [15:0]  miss_count;

  logic [31:0]  s_readdata;
  logic         s_busywait;
  logic         s_mem_read;
  logic [5:0]   s_mem_address;
  logic [3:0]   s_hit_count;
  logic [3:0]   s_miss_count;

  int n_pass = 0;
  int n_total = 0;
  int mem_cnt = 0;
  logic [31:0] exp_q [$];

  icache_assoc dut (
    .clock          (clock),
    .reset          (reset),
    .read           (read),
    .address        (address),
    .flush          (flush),
    .readdata       (readdata),
    .cache_busywait (cache_busywait),
    .mem_read       (mem_read),
    .mem_address    (mem_address),
    .mem_readdata   (mem_readdata),
    .mem_busywait   (mem_busywait),
    .hit_count      (hit_count),
    .miss_count     (miss_count)
  );

  icache_assoc #(.CNT_W(4)) sat (
    .clock          (clock),
    .reset          (reset),
    .read           (read),
    .address        (address),
    .flush          (flush),
    .readdata       (s_readdata),
    .cache_busywait (s_busywait),
    .mem_read       (s_mem_read),
    .mem_address    (s_mem_address),
    .mem_readdata   (mem_readdata),
    .mem_busywait   (mem_busywait),
    .hit_count      (s_hit_count),
    .miss_count     (s_miss_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  function automatic logic [31:0] mem_word(input logic [5:0] blk, input int k);
    return 32'hC0DE_0000 | (32'(blk) << 8) | 32'(k);
  endfunction

  always_comb begin
    mem_readdata = '0;
    for (int k = 0; k < 4; k++)
      mem_readdata[32*k +: 32] = mem_word(mem_address, k);
  end

  always @(posedge clock) mem_cnt <= (mem_read === 1'b1) ? mem_cnt + 1 : 0;
  assign mem_busywait = mem_read && (mem_cnt != LAT - 1);

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", nm, act, exp);
  endtask

  task automatic check_counts(input int h, input int m);
    check("hit_count", 32'(hit_count), 32'(h));
    check("miss_count", 32'(miss_count), 32'(m));
  endtask

  // Enters and leaves one time unit after a rising edge.
  task automatic fetch(input logic [9:0] a, input int exp_stall, input int exp_mr,
                       input int flush_at);
    int stall, mr, bad;
    logic [31:0] want;
    stall = 0; mr = 0; bad = 0;
    exp_q.push_back(mem_word(a[9:4], int'(a[3:2])));
    read = 1'b1;
    address = a;
    while (1) begin
      @(negedge clock);
      if (!cache_busywait || stall > 200) break;
      if (mem_read) begin
        mr++;
        if (mem_address != a[9:4]) bad++;
      end
      stall++;
      @(posedge clock); #1;
      flush = (stall == flush_at);
    end
    want = exp_q.pop_front();
    check($sformatf("readdata@%h", a), readdata, want);
    check($sformatf("stall@%h", a), 32'(stall), 32'(exp_stall));
    check($sformatf("mem_read_cycles@%h", a), 32'(mr), 32'(exp_mr));
    check($sformatf("mem_address_bad@%h", a), 32'(bad), 32'd0);
    @(posedge clock); #1;
    read = 1'b0;
    flush = 1'b0;
  endtask

  task automatic flush_idle();
    flush = 1'b1;
    @(negedge clock);
    check("flush_cycle_busy", 32'(cache_busywait), 32'd0);
    @(posedge clock); #1;
    flush = 1'b0;
    @(negedge clock);
    check("flush_state_busy", 32'(cache_busywait), 32'd1);
    @(posedge clock); #1;
    @(negedge clock);
    check("after_flush_busy", 32'(cache_busywait), 32'd0);
    @(posedge clock); #1;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    read = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset = 1'b1;
  endtask

  localparam int OP_FETCH = 0;
  localparam int OP_FLUSH = 1;
  localparam int OP_COUNT = 2;

  typedef struct {
    int         op;
    logic [9:0] addr;
    bit         hit;
    int         hits;
    int         misses;
  } vec_t;

  vec_t tbl [18];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0]  = '{OP_FETCH, 10'h044, 1'b0, 0, 0};
    tbl[1]  = '{OP_COUNT, 10'h000, 1'b0, 1, 1};
    tbl[2]  = '{OP_FETCH, 10'h048, 1'b1, 0, 0};
    tbl[3]  = '{OP_FETCH, 10'h04C, 1'b1, 0, 0};
    tbl[4]  = '{OP_COUNT, 10'h000, 1'b0, 3, 1};
    tbl[5]  = '{OP_FLUSH, 10'h000, 1'b0, 0, 0};
    tbl[6]  = '{OP_FETCH, 10'h044, 1'b0, 0, 0};
    tbl[7]  = '{OP_FLUSH, 10'h000, 1'b0, 0, 0};
    tbl[8]  = '{OP_FETCH, 10'h000, 1'b0, 0, 0};
    tbl[9]  = '{OP_FETCH, 10'h040, 1'b0, 0, 0};
    tbl[10] = '{OP_FETCH, 10'h080, 1'b0, 0, 0};
    tbl[11] = '{OP_FETCH, 10'h040, 1'b1, 0, 0};
    tbl[12] = '{OP_FETCH, 10'h000, 1'b0, 0, 0};
    tbl[13] = '{OP_FETCH, 10'h080, 1'b1, 0, 0};
    tbl[14] = '{OP_FETCH, 10'h040, 1'b0, 0, 0};
    tbl[15] = '{OP_FETCH, 10'h3F0, 1'b0, 0, 0};
    tbl[16] = '{OP_FETCH, 10'h3FC, 1'b1, 0, 0};
    tbl[17] = '{OP_COUNT, 10'h000, 1'b0, 13, 8};

    reset = 1'b0;
    read = 1'b1;
    address = 10'h044;
    flush = 1'b0;
    @(posedge clock); #1;
    @(negedge clock);
    check("reset_busywait", 32'(cache_busywait), 32'd1);
    check("reset_readdata", readdata, 32'd0);
    check("reset_mem_read", 32'(mem_read), 32'd0);
    check("reset_mem_address", 32'(mem_address), 32'd0);
    check_counts(0, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    read = 1'b0;

    for (int i = 0; i < 18; i++) begin
      case (tbl[i].op)
        OP_FETCH: fetch(tbl[i].addr, tbl[i].hit ? 0 : LAT + 2, tbl[i].hit ? 0 : LAT, -1);
        OP_FLUSH: flush_idle();
        default:  check_counts(tbl[i].hits, tbl[i].misses);
      endcase
    end

    // Flush during the fill: fill completes, flush, then the held read misses again.
    fetch(10'h100, 2 * (LAT + 2) + 1, 2 * LAT, 2);
    check_counts(14, 10);
    fetch(10'h3F0, LAT + 2, LAT, -1);
    check_counts(15, 11);

    // Reset on the third MEM_READ cycle.
    read = 1'b1;
    address = 10'h200;
    repeat (3) begin
      @(posedge clock); #1;
    end
    @(negedge clock);
    check("midfill_mem_read", 32'(mem_read), 32'd1);
    check("midfill_mem_address", 32'(mem_address), 32'h20);
    reset = 1'b0;
    @(posedge clock); #1;
    reset = 1'b1;
    read = 1'b0;
    @(negedge clock);
    check("post_reset_mem_read", 32'(mem_read), 32'd0);
    check("post_reset_mem_address", 32'(mem_address), 32'd0);
    check("post_reset_busywait", 32'(cache_busywait), 32'd0);
    check("post_reset_readdata", readdata, 32'd0);
    check_counts(0, 0);
    @(posedge clock); #1;
    fetch(10'h3F0, LAT + 2, LAT, -1);
    check_counts(1, 1);

    // Counter saturation on the 4-bit instance.
    do_reset();
    fetch(10'h044, LAT + 2, LAT, -1);
    for (int i = 0; i < 20; i++) fetch(10'h044, 0, 0, -1);
    @(negedge clock);
    check("sat_hit_count", 32'(s_hit_count), 32'd15);
    check("sat_miss_count", 32'(s_miss_count), 32'd1);
    check("wide_hit_count", 32'(hit_count), 32'd21);
    check("sat_busywait", 32'(s_busywait), 32'd0);
    check("sat_mem_read", 32'(s_mem_read), 32'd0);
    check("sat_mem_address", 32'(s_mem_address), 32'd0);
    check("sat_readdata", s_readdata, 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
